// File: rtl/alu_pkg.sv
// Shared widths, FSM encoding and constants for the restoring divider.
package alu_pkg;

  localparam int unsigned DW_DEF = 8;
  localparam int unsigned VW_DEF = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Saturated quotient reported for a zero divisor; replicated to DW in the datapath.
  localparam logic [DW_DEF-1:0] DBZ_QUOTIENT = '1;

endpackage

// File: rtl/division_step.sv
// One restoring-division iteration: shift in a dividend bit, compare, conditionally subtract.
module division_step #(
  parameter int unsigned VW = 4
) (
  input  logic [VW:0]   prem,
  input  logic          next_bit,
  input  logic [VW-1:0] divisor,
  output logic [VW:0]   rem_c,
  output logic          q_bit_c
);

  localparam int unsigned PW = VW + 1;
  localparam int unsigned SW = VW + 2;

  logic [SW-1:0] shifted;

  always_comb begin
    shifted = {prem, next_bit};
    q_bit_c = (shifted >= SW'(divisor));
    rem_c   = q_bit_c ? PW'(shifted - SW'(divisor)) : PW'(shifted);
  end

endmodule

// File: rtl/division.sv
// Multi-cycle unsigned restoring divider: DW iterations, MSB first, registered results.
module division
  import alu_pkg::*;
#(
  parameter int unsigned DW = DW_DEF,
  parameter int unsigned VW = VW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] quotient,
  output logic [VW-1:0] remainder,
  output logic          div_by_zero
);

  localparam int unsigned CW = $clog2(DW + 1);

  state_t        state, state_d;
  logic          busy_d, done_d, dbz_d;
  logic [DW-1:0] quotient_d;
  logic [VW-1:0] remainder_d;
  // work holds the unconsumed dividend bits on top and the growing quotient below
  logic [DW-1:0] work, work_d;
  logic [VW-1:0] dvs, dvs_d;
  logic [VW:0]   prem, prem_d;
  logic [CW-1:0] cnt, cnt_d;
  logic [VW:0]   step_rem_c;
  logic          step_q_c;

  division_step #(.VW(VW)) u_step (
    .prem     (prem),
    .next_bit (work[DW-1]),
    .divisor  (dvs),
    .rem_c    (step_rem_c),
    .q_bit_c  (step_q_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      work        <= '0;
      dvs         <= '0;
      prem        <= '0;
      cnt         <= '0;
    end else begin
      state       <= state_d;
      busy        <= busy_d;
      done        <= done_d;
      quotient    <= quotient_d;
      remainder   <= remainder_d;
      div_by_zero <= dbz_d;
      work        <= work_d;
      dvs         <= dvs_d;
      prem        <= prem_d;
      cnt         <= cnt_d;
    end
  end

  always_comb begin
    state_d     = state;
    busy_d      = busy;
    done_d      = 1'b0;
    quotient_d  = quotient;
    remainder_d = remainder;
    dbz_d       = div_by_zero;
    work_d      = work;
    dvs_d       = dvs;
    prem_d      = prem;
    cnt_d       = cnt;

    case (state)
      IDLE: begin
        if (!busy) begin
          if (start) begin
            work_d = dividend;
            dvs_d  = divisor;
            busy_d = 1'b1;
            dbz_d  = 1'b0;
          end
        end else if (dvs == '0) begin
          // operands were latched last cycle; zero divisor skips the iterations
          state_d     = DONE;
          done_d      = 1'b1;
          quotient_d  = {DW{DBZ_QUOTIENT[0]}};
          remainder_d = work[VW-1:0];
          dbz_d       = 1'b1;
        end else begin
          state_d = CALC;
          cnt_d   = '0;
          prem_d  = '0;
        end
      end
      CALC: begin
        work_d = {work[DW-2:0], step_q_c};
        prem_d = step_rem_c;
        cnt_d  = cnt + CW'(1);
        if (cnt == CW'(DW - 1)) begin
          state_d     = DONE;
          done_d      = 1'b1;
          quotient_d  = {work[DW-2:0], step_q_c};
          remainder_d = step_rem_c[VW-1:0];
        end
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_division.sv
// Scoreboard bench for the restoring divider: latency, results, divide-by-zero, start hold, reset abort.
module tb_division;
  import alu_pkg::*;

  localparam int unsigned DW = 8;
  localparam int unsigned VW = 4;

  typedef struct packed {
    logic [DW-1:0] q;
    logic [VW-1:0] r;
    logic          z;
  } res_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [DW-1:0] dividend = '0;
  logic [VW-1:0] divisor = '0;
  logic          busy, done, div_by_zero;
  logic [DW-1:0] quotient;
  logic [VW-1:0] remainder;

  int   checks = 0;
  int   passed = 0;
  int   done_cnt = 0;
  res_t exp_q[$];

  division #(.DW(DW), .VW(VW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (done) done_cnt++;

  initial begin
    #200000;
    $display("FAIL global_timeout simulation did not finish (got running, want finished)");
    $fatal(1, "timeout");
  end

  function automatic res_t model(input logic [DW-1:0] a, input logic [VW-1:0] b);
    res_t e;
    if (b == '0) begin
      e.q = '1;
      e.r = a[VW-1:0];
      e.z = 1'b1;
    end else begin
      e.q = DW'(a / DW'(b));
      e.r = VW'(a % DW'(b));
      e.z = 1'b0;
    end
    return e;
  endfunction

  // Waits for IDLE, pulses start, pushes the expectation and waits for done (lat = edges after E0).
  task automatic run_op(input logic [DW-1:0] a, input logic [VW-1:0] b, input res_t e,
                        output int lat, output res_t got, output logic busy_at);
    @(negedge clk);
    for (int k = 0; k < 20 && busy; k++) @(negedge clk);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    exp_q.push_back(e);
    @(posedge clk);
    #1 start = 1'b0;
    lat     = -1;
    got     = '0;
    busy_at = 1'b0;
    for (int i = 1; i <= 30 && lat < 0; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat     = i;
        got     = '{quotient, remainder, div_by_zero};
        busy_at = busy;
      end
    end
  endtask

  task automatic test_reset;
    #1;
    checks++; if ({busy, done} !== 2'b00) $display("FAIL reset_flags busy/done got %b want 00", {busy, done}); else passed++;
    checks++; if (quotient !== '0) $display("FAIL reset_quotient got %h want 00", quotient); else passed++;
    checks++; if (remainder !== '0) $display("FAIL reset_remainder got %h want 0", remainder); else passed++;
    checks++; if (div_by_zero !== 1'b0) $display("FAIL reset_dbz got %b want 0", div_by_zero); else passed++;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_basic;
    logic [DW-1:0] as[4] = '{8'd6, 8'd200, 8'd255, 8'd5};
    logic [VW-1:0] bs[4] = '{4'd2, 4'd7, 4'd1, 4'd9};
    res_t          es[4] = '{'{8'd3, 4'd0, 1'b0}, '{8'd28, 4'd4, 1'b0},
                             '{8'd255, 4'd0, 1'b0}, '{8'd0, 4'd5, 1'b0}};
    int lat; res_t got, e; logic b_at;
    for (int i = 0; i < 4; i++) begin
      run_op(as[i], bs[i], es[i], lat, got, b_at);
      e = exp_q.pop_front();
      checks++; if (lat !== 9) $display("FAIL basic_latency[%0d] got %0d want 9", i, lat); else passed++;
      checks++; if (got !== e) $display("FAIL basic_result[%0d] got q=%0d r=%0d z=%b want q=%0d r=%0d z=%b", i, got.q, got.r, got.z, e.q, e.r, e.z); else passed++;
      checks++; if (b_at !== 1'b1) $display("FAIL basic_busy_at_done[%0d] got %b want 1", i, b_at); else passed++;
    end
    repeat (3) @(posedge clk);
    #1;
    checks++; if ({busy, done} !== 2'b00) $display("FAIL hold_flags got %b want 00", {busy, done}); else passed++;
    checks++; if ({quotient, remainder} !== {8'd0, 4'd5}) $display("FAIL hold_result got q=%0d r=%0d want q=0 r=5", quotient, remainder); else passed++;
  endtask

  task automatic test_div_zero;
    int lat; res_t got, e; logic b_at;
    run_op(8'd13, 4'd0, '{8'hFF, 4'hD, 1'b1}, lat, got, b_at);
    e = exp_q.pop_front();
    checks++; if (lat !== 1) $display("FAIL dbz_latency got %0d want 1", lat); else passed++;
    checks++; if (got !== e) $display("FAIL dbz_result got q=%h r=%h z=%b want q=%h r=%h z=%b", got.q, got.r, got.z, e.q, e.r, e.z); else passed++;
    run_op(8'd9, 4'd4, '{8'd2, 4'd1, 1'b0}, lat, got, b_at);
    e = exp_q.pop_front();
    checks++; if (got !== e) $display("FAIL dbz_cleared got q=%0d r=%0d z=%b want q=%0d r=%0d z=%b", got.q, got.r, got.z, e.q, e.r, e.z); else passed++;
  endtask

  task automatic test_start_held;
    int lat, base; res_t got, e;
    @(negedge clk);
    for (int k = 0; k < 20 && busy; k++) @(negedge clk);
    base     = done_cnt;
    dividend = 8'd100;
    divisor  = 4'd3;
    start    = 1'b1;
    exp_q.push_back('{8'd33, 4'd1, 1'b0});
    @(posedge clk);
    lat = -1;
    got = '0;
    for (int i = 1; i <= 30 && lat < 0; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat   = i;
        got   = '{quotient, remainder, div_by_zero};
        start = 1'b0;
      end else begin
        dividend = DW'($urandom);
        divisor  = VW'($urandom_range(0, 15));
      end
    end
    start = 1'b0;
    e = exp_q.pop_front();
    repeat (4) @(posedge clk);
    #1;
    checks++; if (lat !== 9) $display("FAIL held_latency got %0d want 9", lat); else passed++;
    checks++; if (got !== e) $display("FAIL held_result got q=%0d r=%0d z=%b want q=%0d r=%0d z=%b", got.q, got.r, got.z, e.q, e.r, e.z); else passed++;
    checks++; if (done_cnt - base !== 1) $display("FAIL held_done_count got %0d want 1", done_cnt - base); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL held_idle_after got busy=%b want 0", busy); else passed++;
  endtask

  task automatic test_reset_mid;
    int lat, base; res_t got, e; logic b_at;
    @(negedge clk);
    for (int k = 0; k < 20 && busy; k++) @(negedge clk);
    dividend = 8'd77;
    divisor  = 4'd5;
    start    = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b1) $display("FAIL mid_busy_before_reset got %b want 1", busy); else passed++;
    #1 rst_n = 1'b0;
    #1;
    checks++; if ({busy, done, quotient, remainder, div_by_zero} !== '0) $display("FAIL mid_reset_outputs got b=%b d=%b q=%h r=%h z=%b want all 0", busy, done, quotient, remainder, div_by_zero); else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    base = done_cnt;
    repeat (12) @(posedge clk);
    #1;
    checks++; if (done_cnt !== base) $display("FAIL mid_no_done got %0d pulses want 0", done_cnt - base); else passed++;
    run_op(8'd77, 4'd5, '{8'd15, 4'd2, 1'b0}, lat, got, b_at);
    e = exp_q.pop_front();
    checks++; if (lat !== 9 || got !== e) $display("FAIL mid_recover got lat=%0d q=%0d r=%0d want lat=9 q=%0d r=%0d", lat, got.q, got.r, e.q, e.r); else passed++;
  endtask

  task automatic test_back_to_back;
    int lat, base; res_t got, e; logic b_at;
    logic [DW-1:0] a; logic [VW-1:0] b;
    base = done_cnt;
    for (int i = 0; i < 8; i++) begin
      a = DW'($urandom);
      b = VW'($urandom_range((i == 3) ? 0 : 1, (i == 3) ? 0 : 15));
      run_op(a, b, model(a, b), lat, got, b_at);
      e = exp_q.pop_front();
      checks++; if (lat !== ((b == '0) ? 1 : 9)) $display("FAIL b2b_latency[%0d] got %0d want %0d", i, lat, (b == '0) ? 1 : 9); else passed++;
      checks++; if (got !== e) $display("FAIL b2b_result[%0d] %0d/%0d got q=%0d r=%0d z=%b want q=%0d r=%0d z=%b", i, a, b, got.q, got.r, got.z, e.q, e.r, e.z); else passed++;
    end
    @(negedge clk);
    checks++; if (done_cnt - base !== 8) $display("FAIL b2b_done_count got %0d want 8", done_cnt - base); else passed++;
    checks++; if (exp_q.size() !== 0) $display("FAIL scoreboard_empty got %0d want 0", exp_q.size()); else passed++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_div_zero();
    test_start_held();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
